// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  pipe_pkg : shared decode/execute stage payload types and widths
//  Rev 1.0
// ============================================================================
package pipe_pkg;

   typedef struct packed {
      logic       alusrc;
      logic       mem2reg;
      logic       regwr;
      logic       memrd;
      logic       memwr;
      logic       branch;
      logic [1:0] aluop;
   } id_ex_ctrl_t;

   typedef struct packed {
      logic [11:0] pc;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] inst;
      logic [5:0]  rd;
      logic [3:0]  alu_ctrl;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
   } id_ex_data_t;

   localparam int PIPE_CTRL_W = $bits(id_ex_ctrl_t);
   localparam int PIPE_DATA_W = $bits(id_ex_data_t);

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_entry.sv
`default_nettype none
// ============================================================================
//  pipe_entry : one valid+ctrl+data slot; clear zeroes valid/ctrl, keeps data
//  Rev 1.0
// ============================================================================
module pipe_entry
   import pipe_pkg::*;
#(
   parameter int CTRL_W = PIPE_CTRL_W,
   parameter int DATA_W = PIPE_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              clear_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] data_o
);

   logic              valid_q, valid_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [DATA_W-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      if (clear_i) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end else if (load_i) begin
         valid_d = 1'b1;
         ctrl_d  = ctrl_i;
         data_d  = data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign ctrl_o  = ctrl_q;
   assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  pipe_stage_reg : valid/ready pipeline stage with optional skid slot,
//                   stall bubbles, flush and saturating bubble counter
//  Rev 1.0
// ============================================================================
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = 160,
   parameter int CTRL_W = PIPE_CTRL_W,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              stall,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  bubble_cnt
);

   logic              live_q;
   logic              main_v, skid_v;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_src_ctrl;
   logic [DATA_W-1:0] main_data, skid_data, main_src_data;
   logic              drain, accept;
   logic              main_load, main_clear, bubble_inc;
   logic [CNT_W-1:0]  bubble_q, bubble_d;

   assign drain    = out_ready | ~main_v;
   assign in_ready = live_q & ~stall & ((SKID != 0) ? ~skid_v : drain);
   assign accept   = in_valid & in_ready;

   // A parked skid entry always refills main before any new input.
   assign main_src_ctrl = skid_v ? skid_ctrl : in_ctrl;
   assign main_src_data = skid_v ? skid_data : in_data;
   assign main_load     = ~flush & drain & (skid_v | accept);
   assign main_clear    = flush | (drain & ~skid_v & ~accept);
   assign bubble_inc    = ~flush & drain & ~skid_v & ~accept & stall;

   pipe_entry #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
   ) u_main (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (main_load),
      .clear_i (main_clear),
      .ctrl_i  (main_src_ctrl),
      .data_i  (main_src_data),
      .valid_o (main_v),
      .ctrl_o  (main_ctrl),
      .data_o  (main_data)
   );

   generate
      if (SKID != 0) begin : g_skid
         logic skid_load, skid_clear;

         assign skid_load  = ~flush & ~drain & accept;
         assign skid_clear = flush | (drain & skid_v);

         pipe_entry #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W)
         ) u_skid (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (skid_load),
            .clear_i (skid_clear),
            .ctrl_i  (in_ctrl),
            .data_i  (in_data),
            .valid_o (skid_v),
            .ctrl_o  (skid_ctrl),
            .data_o  (skid_data)
         );
      end else begin : g_no_skid
         assign skid_v    = 1'b0;
         assign skid_ctrl = '0;
         assign skid_data = '0;
      end
   endgenerate

   always_comb begin
      bubble_d = bubble_q;
      if (bubble_inc && (bubble_q != {CNT_W{1'b1}})) begin
         bubble_d = bubble_q + CNT_W'(1);
      end
   end

   // live_q keeps in_ready low until the first clock after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live_q   <= 1'b0;
         bubble_q <= '0;
      end else begin
         live_q   <= 1'b1;
         bubble_q <= bubble_d;
      end
   end

   assign out_valid  = main_v;
   assign out_ctrl   = main_ctrl;
   assign out_data   = main_data;
   assign occupancy  = {1'b0, main_v} + {1'b0, skid_v};
   assign bubble_cnt = bubble_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  tb_pipe_stage_reg : directed self-checking bench for pipe_stage_reg
//  Rev 1.0
// ============================================================================
module tb_pipe_stage_reg;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, stall, flush, out_ready;
   logic [7:0]   in_ctrl;
   logic [159:0] in_data;

   logic         in_ready, out_valid;
   logic [7:0]   out_ctrl;
   logic [159:0] out_data;
   logic [1:0]   occupancy;
   logic [15:0]  bubble_cnt;

   logic         in_ready_s, out_valid_s;
   logic [7:0]   out_ctrl_s;
   logic [159:0] out_data_s;
   logic [1:0]   occupancy_s;
   logic [3:0]   bubble_cnt_s;

   logic         in_ready_n, out_valid_n;
   logic [7:0]   out_ctrl_n;
   logic [159:0] out_data_n;
   logic [1:0]   occupancy_n;
   logic [15:0]  bubble_cnt_n;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipe_stage_reg dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .stall(stall), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
      .out_data(out_data), .occupancy(occupancy), .bubble_cnt(bubble_cnt)
   );

   pipe_stage_reg #(.CNT_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
      .in_ctrl(in_ctrl), .in_data(in_data), .stall(stall), .flush(flush),
      .out_valid(out_valid_s), .out_ready(out_ready), .out_ctrl(out_ctrl_s),
      .out_data(out_data_s), .occupancy(occupancy_s), .bubble_cnt(bubble_cnt_s)
   );

   pipe_stage_reg #(.SKID(0)) dut_ns (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n),
      .in_ctrl(in_ctrl), .in_data(in_data), .stall(stall), .flush(flush),
      .out_valid(out_valid_n), .out_ready(out_ready), .out_ctrl(out_ctrl_n),
      .out_data(out_data_n), .occupancy(occupancy_n), .bubble_cnt(bubble_cnt_n)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 0; stall = 0; flush = 0; out_ready = 0;
      in_ctrl = '0; in_data = '0;
      #3;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0h want 0", out_valid); end
      n_vec++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
      n_vec++; if (out_ctrl !== 8'h00) begin n_err++; $display("FAIL reset_out_ctrl got %0h want 0", out_ctrl); end
      n_vec++; if (out_data !== 160'd0) begin n_err++; $display("FAIL reset_out_data got %0h want 0", out_data); end
      n_vec++; if (bubble_cnt !== 16'd0) begin n_err++; $display("FAIL reset_bubble_cnt got %0d want 0", bubble_cnt); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %0h want 0", in_ready); end
      tick(); tick();
      #2 rst_n = 1'b1;
      tick();
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got %0h want 1", in_ready); end
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_ctrl = 8'(i); in_data = 160'(i);
         #1;
         n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d] got %0h want 1", i, in_ready); end
         tick();
         n_vec++; if (out_valid !== 1'b1 || out_data !== 160'(i) || out_ctrl !== 8'(i))
            begin n_err++; $display("FAIL stream_out[%0d] got v=%0h d=%0h c=%0h want v=1 d=%0h c=%0h", i, out_valid, out_data, out_ctrl, i, i); end
      end
      in_valid = 1'b0;
      tick();
      n_vec++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin n_err++; $display("FAIL stream_tail got v=%0h c=%0h want v=0 c=0", out_valid, out_ctrl); end
      n_vec++; if (out_data !== 160'd8) begin n_err++; $display("FAIL stream_tail_data got %0h want 8", out_data); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid = 1'b1; in_ctrl = 8'h5A; in_data = 160'hA;
      tick();
      n_vec++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_first got occ=%0d rdy=%0h want occ=1 rdy=1", occupancy, in_ready); end
      in_ctrl = 8'hA5; in_data = 160'hB;
      tick();
      n_vec++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full got occ=%0d rdy=%0h want occ=2 rdy=0", occupancy, in_ready); end
      n_vec++; if (out_data !== 160'hA) begin n_err++; $display("FAIL bp_head got %0h want a", out_data); end
      in_valid = 1'b0;
      tick();
      n_vec++; if (occupancy !== 2'd2 || out_data !== 160'hA || out_ctrl !== 8'h5A) begin n_err++; $display("FAIL bp_hold got occ=%0d d=%0h c=%0h want occ=2 d=a c=5a", occupancy, out_data, out_ctrl); end
      out_ready = 1'b1;
      tick();
      n_vec++; if (out_valid !== 1'b1 || out_data !== 160'hB || out_ctrl !== 8'hA5 || occupancy !== 2'd1)
         begin n_err++; $display("FAIL bp_second got v=%0h d=%0h c=%0h occ=%0d want v=1 d=b c=a5 occ=1", out_valid, out_data, out_ctrl, occupancy); end
      tick();
      n_vec++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_err++; $display("FAIL bp_empty got v=%0h occ=%0d want v=0 occ=0", out_valid, occupancy); end
   endtask

   task automatic test_stall();
      out_ready = 1'b1;
      in_valid = 1'b1; in_ctrl = 8'h33; in_data = 160'h100;
      tick();
      n_vec++; if (out_valid !== 1'b1 || out_data !== 160'h100) begin n_err++; $display("FAIL stall_pre got v=%0h d=%0h want v=1 d=100", out_valid, out_data); end
      stall = 1'b1; in_ctrl = 8'h44; in_data = 160'h200;
      for (int i = 1; i <= 3; i++) begin
         #1;
         n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d] got %0h want 0", i, in_ready); end
         tick();
         n_vec++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin n_err++; $display("FAIL stall_bubble[%0d] got v=%0h c=%0h want v=0 c=0", i, out_valid, out_ctrl); end
         n_vec++; if (bubble_cnt !== 16'(i)) begin n_err++; $display("FAIL stall_cnt[%0d] got %0d want %0d", i, bubble_cnt, i); end
      end
      stall = 1'b0;
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_rdy got %0h want 1", in_ready); end
      tick();
      n_vec++; if (out_valid !== 1'b1 || out_data !== 160'h200 || out_ctrl !== 8'h44) begin n_err++; $display("FAIL stall_resume got v=%0h d=%0h c=%0h want v=1 d=200 c=44", out_valid, out_data, out_ctrl); end
      in_valid = 1'b0;
      tick();
      n_vec++; if (bubble_cnt !== 16'd3) begin n_err++; $display("FAIL stall_cnt_final got %0d want 3", bubble_cnt); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid = 1'b1; in_ctrl = 8'h11; in_data = 160'h300;
      tick();
      in_ctrl = 8'h22; in_data = 160'h400;
      tick();
      n_vec++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL flush_fill got occ=%0d want 2", occupancy); end
      flush = 1'b1; in_ctrl = 8'h33; in_data = 160'h500;
      tick();
      n_vec++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ctrl !== 8'h00) begin n_err++; $display("FAIL flush_full got v=%0h occ=%0d c=%0h want v=0 occ=0 c=0", out_valid, occupancy, out_ctrl); end
      n_vec++; if (out_data !== 160'h300) begin n_err++; $display("FAIL flush_data_held got %0h want 300", out_data); end
      flush = 1'b0; in_ctrl = 8'h44; in_data = 160'h600;
      tick();
      n_vec++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL flush_refill got occ=%0d want 1", occupancy); end
      flush = 1'b1; in_ctrl = 8'h55; in_data = 160'h700;
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready got %0h want 1", in_ready); end
      tick();
      n_vec++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_err++; $display("FAIL flush_accept got v=%0h occ=%0d want v=0 occ=0", out_valid, occupancy); end
      flush = 1'b0; in_valid = 1'b0;
      tick();
      n_vec++; if (occupancy !== 2'd0 || out_data !== 160'h600) begin n_err++; $display("FAIL flush_discard got occ=%0d d=%0h want occ=0 d=600", occupancy, out_data); end
      stall = 1'b1; flush = 1'b1; out_ready = 1'b1;
      tick();
      n_vec++; if (bubble_cnt !== 16'd3) begin n_err++; $display("FAIL flush_stall_cnt got %0d want 3", bubble_cnt); end
      stall = 1'b0; flush = 1'b0;
   endtask

   task automatic test_saturation();
      stall = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 11) begin
            n_vec++; if (bubble_cnt_s !== 4'd14) begin n_err++; $display("FAIL sat_pre got %0d want 14", bubble_cnt_s); end
         end else if (i >= 12) begin
            n_vec++; if (bubble_cnt_s !== 4'd15) begin n_err++; $display("FAIL sat_hold[%0d] got %0d want 15", i, bubble_cnt_s); end
         end
      end
      n_vec++; if (bubble_cnt !== 16'd23) begin n_err++; $display("FAIL sat_wide got %0d want 23", bubble_cnt); end
      stall = 1'b0;
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h66; in_data = 160'h800;
      tick();
      in_data = 160'h801;
      tick();
      in_valid = 1'b0;
      n_vec++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL areset_fill got occ=%0d want 2", occupancy); end
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_data !== 160'd0)
         begin n_err++; $display("FAIL areset_state got occ=%0d v=%0h c=%0h d=%0h want all 0", occupancy, out_valid, out_ctrl, out_data); end
      n_vec++; if (bubble_cnt !== 16'd0 || bubble_cnt_s !== 4'd0) begin n_err++; $display("FAIL areset_cnt got %0d/%0d want 0/0", bubble_cnt, bubble_cnt_s); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL areset_in_ready got %0h want 0", in_ready); end
      tick();
      #2 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_no_skid();
      out_ready = 1'b0; stall = 1'b0;
      in_valid = 1'b1; in_ctrl = 8'h77; in_data = 160'h900;
      #1;
      n_vec++; if (in_ready_n !== 1'b1) begin n_err++; $display("FAIL ns_rdy_empty got %0h want 1", in_ready_n); end
      tick();
      n_vec++; if (out_valid_n !== 1'b1 || out_data_n !== 160'h900 || occupancy_n !== 2'd1)
         begin n_err++; $display("FAIL ns_load got v=%0h d=%0h occ=%0d want v=1 d=900 occ=1", out_valid_n, out_data_n, occupancy_n); end
      n_vec++; if (in_ready_n !== 1'b0) begin n_err++; $display("FAIL ns_rdy_full got %0h want 0", in_ready_n); end
      out_ready = 1'b1;
      #1;
      n_vec++; if (in_ready_n !== 1'b1) begin n_err++; $display("FAIL ns_rdy_drain got %0h want 1", in_ready_n); end
      stall = 1'b1;
      #1;
      n_vec++; if (in_ready_n !== 1'b0) begin n_err++; $display("FAIL ns_rdy_stall got %0h want 0", in_ready_n); end
      stall = 1'b0; in_valid = 1'b0;
      tick();
      n_vec++; if (out_valid_n !== 1'b0 || out_ctrl_n !== 8'h00) begin n_err++; $display("FAIL ns_drain got v=%0h c=%0h want v=0 c=0", out_valid_n, out_ctrl_n); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_stall();
      test_flush();
      test_saturation();
      test_async_reset();
      test_no_skid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
